// File: rtl/registro_universal_pkg.sv
// Shared mode and direction encodings
// for the universal shift register slice.
`ifndef REGISTRO_UNIVERSAL_PKG_SV
`define REGISTRO_UNIVERSAL_PKG_SV
package registro_universal_pkg;

  localparam logic [1:0] MODO_SERIAL = 2'b00;
  localparam logic [1:0] MODO_ROTA   = 2'b01;
  localparam logic [1:0] MODO_CARGA  = 2'b10;
  localparam logic [1:0] MODO_RETEN  = 2'b11;

  localparam logic DIR_DER = 1'b0;
  localparam logic DIR_IZQ = 1'b1;

endpackage
`endif

// File: rtl/registro_universal_if.sv
// Control, data and status bundle of the
// universal shift register.
interface registro_universal_if #(
  parameter int N  = 4,
  parameter int CW = $clog2(N+1)
);

  logic          enb;
  logic [1:0]    modo;
  logic          dir;
  logic          s_in;
  logic [N-1:0]  d;
  logic [N-1:0]  q;
  logic          s_der;
  logic          s_izq;
  logic [CW-1:0] cuenta;
  logic          vacio;
  logic          vuelta;

  modport master (
    output enb, modo, dir, s_in, d,
    input  q, s_der, s_izq,
    input  cuenta, vacio, vuelta
  );

  modport slave (
    input  enb, modo, dir, s_in, d,
    output q, s_der, s_izq,
    output cuenta, vacio, vuelta
  );

endinterface

// File: rtl/registro_universal_contador.sv
// Shift/rotate counter with empty flag
// and rotation-wrap pulse.
module contador_desplazamiento
  import registro_universal_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic [1:0]    modo,
  output logic [CW-1:0] cuenta,
  output logic          vacio,
  output logic          vuelta
);

  localparam logic [CW-1:0] C_MAX  = CW'(N);
  localparam logic [CW-1:0] C_ULT  = CW'(N-1);
  localparam logic [CW-1:0] C_UNO  = CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cuenta <= '0;
      vacio  <= 1'b1;
      vuelta <= 1'b0;
    end else begin
      vuelta <= 1'b0;
      if (enb) begin
        unique case (1'b1)
          (modo == MODO_CARGA): begin
            cuenta <= '0;
            vacio  <= 1'b0;
          end
          (modo == MODO_SERIAL): begin
            if (cuenta < C_MAX)
              cuenta <= cuenta + C_UNO;
            if (cuenta >= C_ULT)
              vacio <= 1'b1;
          end
          (modo == MODO_ROTA): begin
            // saturated count restarts at 1, no wrap
            if (cuenta >= C_MAX)
              cuenta <= C_UNO;
            else if (cuenta == C_ULT) begin
              cuenta <= '0;
              vuelta <= 1'b1;
            end else
              cuenta <= cuenta + C_UNO;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/registro_universal.sv
// N-bit universal shift register feeding
// the serial-output selector.
module registro_universal
  import registro_universal_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = $clog2(N+1)
) (
  input  logic clk,
  input  logic rst,
  registro_universal_if.slave bus
);

  logic [N-1:0]  q_r;
  logic [N-1:0]  q_nx;
  logic [CW-1:0] cuenta;
  logic          vacio;
  logic          vuelta;

  always_comb begin
    q_nx = q_r;
    unique case (1'b1)
      (bus.modo == MODO_CARGA):
        q_nx = bus.d;
      (bus.modo == MODO_SERIAL):
        q_nx = (bus.dir == DIR_IZQ)
             ? {q_r[N-2:0], bus.s_in}
             : {bus.s_in, q_r[N-1:1]};
      (bus.modo == MODO_ROTA):
        q_nx = (bus.dir == DIR_IZQ)
             ? {q_r[N-2:0], q_r[N-1]}
             : {q_r[0], q_r[N-1:1]};
      default:
        q_nx = q_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      q_r <= '0;
    else if (bus.enb)
      q_r <= q_nx;
  end

  contador_desplazamiento #(
    .N  (N),
    .CW (CW)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .enb    (bus.enb),
    .modo   (bus.modo),
    .cuenta (cuenta),
    .vacio  (vacio),
    .vuelta (vuelta)
  );

  assign bus.q      = q_r;
  assign bus.s_der  = q_r[0];
  assign bus.s_izq  = q_r[N-1];
  assign bus.cuenta = cuenta;
  assign bus.vacio  = vacio;
  assign bus.vuelta = vuelta;

endmodule
